reg_file_rename: RTL

- Architectural register file with rename tags. It is the consumer of the ROB commit-write interface: reg, ROB tag and value.
- Holds 32 committed values plus a per-register "pending ROB tag". The decoder uses it to resolve source operands and to record the destination tag of each newly dispatched instruction.
- A misbranch flush discards all pending tags, leaving only committed state.

---
 rtl/reg_file_rename_if.sv | 36 +++
 rtl/reg_file_rename.sv | 80 ++++++++
 2 files changed

// File: rtl/reg_file_rename_if.sv
// Decoder / ROB-commit side bundle of the renaming register file.
// master drives commits, assigns, flush and queries; slave returns operand values and tags.
interface reg_file_rename_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned ROB_TAG_W = 8
) ();
  logic                 ena;
  logic [REG_W-1:0]     in_commit_reg;
  logic [ROB_TAG_W-1:0] in_commit_rob;
  logic [DATA_W-1:0]    in_commit_value;
  logic                 in_assign_ena;
  logic [REG_W-1:0]     in_assign_reg;
  logic [ROB_TAG_W-1:0] in_assign_rob;
  logic                 in_misbranch;
  logic [REG_W-1:0]     in_query_reg1;
  logic [REG_W-1:0]     in_query_reg2;
  logic [DATA_W-1:0]    out_value1;
  logic [ROB_TAG_W-1:0] out_tag1;
  logic [DATA_W-1:0]    out_value2;
  logic [ROB_TAG_W-1:0] out_tag2;

  modport master (
    output ena, in_commit_reg, in_commit_rob, in_commit_value,
    output in_assign_ena, in_assign_reg, in_assign_rob, in_misbranch,
    output in_query_reg1, in_query_reg2,
    input  out_value1, out_tag1, out_value2, out_tag2
  );

  modport slave (
    input  ena, in_commit_reg, in_commit_rob, in_commit_value,
    input  in_assign_ena, in_assign_reg, in_assign_rob, in_misbranch,
    input  in_query_reg1, in_query_reg2,
    output out_value1, out_tag1, out_value2, out_tag2
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register pending ROB tags (tag 0 = value is final).
// Optional same-cycle commit forwarding on the query ports: define REGFILE_COMMIT_BYPASS_EN.
module reg_file_rename #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned ROB_TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  reg_file_rename_if.slave   rf_io
);

  localparam int unsigned NumRegs = 2 ** REG_W;

  logic [DATA_W-1:0]    value_q [NumRegs];
  logic [DATA_W-1:0]    value_d [NumRegs];
  logic [ROB_TAG_W-1:0] tag_q   [NumRegs];
  logic [ROB_TAG_W-1:0] tag_d   [NumRegs];

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      value_d[i] = value_q[i];
      tag_d[i]   = tag_q[i];
    end
    if (rf_io.ena) begin
      if (rf_io.in_commit_reg != '0) begin
        value_d[rf_io.in_commit_reg] = rf_io.in_commit_value;
        // A younger producer keeps ownership unless this commit is the latest rename.
        if (tag_q[rf_io.in_commit_reg] == rf_io.in_commit_rob) begin
          tag_d[rf_io.in_commit_reg] = '0;
        end
      end
      if (rf_io.in_misbranch) begin
        for (int i = 0; i < NumRegs; i++) begin
          tag_d[i] = '0;
        end
      end else if (rf_io.in_assign_ena && (rf_io.in_assign_reg != '0)) begin
        tag_d[rf_io.in_assign_reg] = rf_io.in_assign_rob;
      end
    end
    value_d[0] = '0;
    tag_d[0]   = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  always_comb begin
    rf_io.out_value1 = value_q[rf_io.in_query_reg1];
    rf_io.out_tag1   = tag_q[rf_io.in_query_reg1];
    rf_io.out_value2 = value_q[rf_io.in_query_reg2];
    rf_io.out_tag2   = tag_q[rf_io.in_query_reg2];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (rf_io.ena && rst && (rf_io.in_commit_reg != '0)) begin
      if ((rf_io.in_query_reg1 == rf_io.in_commit_reg) &&
          (tag_q[rf_io.in_query_reg1] == rf_io.in_commit_rob)) begin
        rf_io.out_value1 = rf_io.in_commit_value;
        rf_io.out_tag1   = '0;
      end
      if ((rf_io.in_query_reg2 == rf_io.in_commit_reg) &&
          (tag_q[rf_io.in_query_reg2] == rf_io.in_commit_rob)) begin
        rf_io.out_value2 = rf_io.in_commit_value;
        rf_io.out_tag2   = '0;
      end
    end
`endif
  end

endmodule
